pc_call_ctrl: RTL
=================

PC_CALL_CTRL -- requirements
Module: pc_call_ctrl

Interface
REQ-001 SHALL have parameter AW, 11, program-counter and return-address width.
REQ-002 SHALL have parameter DEPTH, 16, number of return-stack entries tracked for overflow and underflow.
REQ-003 SHALL have port clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  leave IDLE and begin fetching.
REQ-006 SHALL have port stall  input  1  hold PC and all state; no stack command is issued.
REQ-007 SHALL have port op  input  3  decoded op: 0 NEXT, 1 JMP, 2 JZ, 3 CALL, 4 RET, 5 HLT; codes 6 and 7 SHALL be treated as NEXT.
REQ-008 SHALL have port zero_flag  input  1  condition for JZ.
REQ-009 SHALL have port target  input  AW  jump or call destination.
REQ-010 SHALL have port stack_out  input  AW  current top-of-stack from the return stack; it is combinational.
REQ-011 SHALL have port pc  output  AW  current program counter.
REQ-012 SHALL have port push  output  1  one-cycle push command to the return stack.
REQ-013 SHALL have port pop  output  1  one-cycle pop command to the return stack.
REQ-014 SHALL have port stack_in  output  AW  return address to push.
REQ-015 SHALL have port depth  output  5  number of valid stack entries, 0..DEPTH.
REQ-016 SHALL have port state  output  2  encoding: 0 IDLE, 1 RUN, 2 HALT, 3 FAULT.
REQ-017 SHALL have port fault_code  output  2  encoding: 0 none, 1 overflow, 2 underflow.

Function
REQ-018 SHALL implement a four-state FSM: IDLE, RUN, HALT, FAULT.
REQ-019 IDLE SHALL move to RUN on start; pc SHALL stay at 0.
REQ-020 In RUN, ops SHALL be evaluated only when stall=0; a stalled cycle SHALL change nothing.
REQ-021 NEXT SHALL set pc to pc+1, modulo 2^AW; 0x7FF SHALL wrap to 0x000.
REQ-022 JMP SHALL set pc to target.
REQ-023 JZ SHALL set pc to target if zero_flag=1, else pc+1.
REQ-024 CALL with depth<DEPTH SHALL, combinationally in that cycle, assert push=1 and stack_in=pc+1 (wrapped).
REQ-025 Such a CALL SHALL, at the clock edge, set pc to target and depth to depth+1.
REQ-026 RET with depth>0 SHALL, combinationally in that cycle, assert pop=1.
REQ-027 Such a RET SHALL, at the clock edge, set pc to stack_out and depth to depth-1.
REQ-028 CALL with depth=DEPTH SHALL issue no push, leave pc unchanged, enter FAULT and set fault_code=1.
REQ-029 RET with depth=0 SHALL issue no pop, leave pc unchanged, enter FAULT and set fault_code=2.
REQ-030 HLT SHALL enter HALT with pc unchanged.
REQ-031 HALT and FAULT SHALL be absorbing; only reset exits them, and push and pop SHALL stay 0.
REQ-032 push and pop SHALL never both be 1 in the same cycle.
REQ-033 push and pop SHALL be 0 in IDLE, HALT, FAULT, during stall and during reset.
REQ-034 push, pop and stack_in SHALL be combinational from current state and inputs so the return stack samples them at the same edge.
REQ-035 Priority SHALL be: reset > state (HALT/FAULT hold) > stall > op.

Reset
REQ-036 When reset=1 at a clock edge, the block SHALL set pc=0, depth=0, state=IDLE and fault_code=0.
REQ-037 When reset=1, push and pop SHALL be 0 in that same cycle.
REQ-038 Reset SHALL take effect in any state, including mid-CALL or mid-RET; the return stack shares the same reset, so depth=0 stays consistent with it.

Verification
REQ-039 Reset, start, three NEXT -> pc 0,1,2,3; push=pop=0.
REQ-040 pc=0x005, CALL target=0x100 -> push=1 and stack_in=0x006 in that cycle; next cycle pc=0x100, depth=1; then RET with stack_out=0x006 -> pop=1, then pc=0x006, depth=0.
REQ-041 Sixteen nested CALLs -> depth=16; seventeenth CALL -> push=0, state=FAULT, fault_code=1, pc held.
REQ-042 RET at depth=0 -> pop=0, state=FAULT, fault_code=2; then reset -> IDLE, pc=0, fault_code=0.
REQ-043 pc=0x7FF, NEXT -> pc=0x000; JZ target=0x040 with zero_flag=0 -> pc=0x001; JZ with zero_flag=1 -> pc=0x040.
REQ-044 CALL held with stall=1 for 3 cycles -> push=0 and pc unchanged throughout; stall release -> exactly one push.

Source files
------------

// File: rtl/pc_call_ctrl.sv
// Program-counter sequencer with CALL/RET control for an external return stack.
// Tracks stack occupancy locally so overflow/underflow are caught before a bad push/pop.
module pc_call_ctrl #(
  parameter int AW    = 11,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic [2:0]    op,
  input  logic          zero_flag,
  input  logic [AW-1:0] target,
  input  logic [AW-1:0] stack_out,
  output logic [AW-1:0] pc,
  output logic          push,
  output logic          pop,
  output logic [AW-1:0] stack_in,
  output logic [4:0]    depth,
  output logic [1:0]    state,
  output logic [1:0]    fault_code
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2, S_FAULT = 2'd3} state_t;
  typedef enum logic [2:0] {
    OP_NEXT = 3'd0, OP_JMP = 3'd1, OP_JZ = 3'd2, OP_CALL = 3'd3, OP_RET = 3'd4, OP_HLT = 3'd5
  } op_t;

  localparam logic [1:0] F_NONE = 2'd0;
  localparam logic [1:0] F_OVF  = 2'd1;
  localparam logic [1:0] F_UNF  = 2'd2;
  localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [4:0]    depth_q, depth_d;
  logic [1:0]    fault_q, fault_d;

  logic [AW-1:0] pc_inc;
  logic          run_op;
  logic          can_push;
  logic          can_pop;

  assign pc_inc   = pc_q + AW'(1);
  assign run_op   = (state_q == S_RUN) && !stall;
  assign can_push = depth_q < DEPTH_MAX;
  assign can_pop  = depth_q != 5'd0;

  // State register; reset is synchronous so it shares timing with the return stack.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      depth_q <= '0;
      fault_q <= F_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic; HALT and FAULT fall through to the hold defaults.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (!stall) begin
          case (op)
            OP_JMP: pc_d = target;
            OP_JZ:  pc_d = zero_flag ? target : pc_inc;
            OP_CALL: begin
              if (can_push) begin
                pc_d    = target;
                depth_d = depth_q + 5'd1;
              end else begin
                state_d = S_FAULT;
                fault_d = F_OVF;
              end
            end
            OP_RET: begin
              if (can_pop) begin
                pc_d    = stack_out;
                depth_d = depth_q - 5'd1;
              end else begin
                state_d = S_FAULT;
                fault_d = F_UNF;
              end
            end
            OP_HLT:  state_d = S_HALT;
            default: pc_d = pc_inc;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Stack commands are combinational so the return stack acts on the same edge.
  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    stack_in = pc_inc;
    if (!reset && run_op) begin
      push = (op == OP_CALL) && can_push;
      pop  = (op == OP_RET) && can_pop;
    end
  end

  assign pc         = pc_q;
  assign depth      = depth_q;
  assign state      = state_q;
  assign fault_code = fault_q;

endmodule
